// File: rtl/sequential_multiplier_pkg.sv
// Shared definitions for the sequential arithmetic blocks: FSM state
// encoding and the default operand width.
package sequential_multiplier_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/sequential_multiplier.sv
// Multi-cycle unsigned shift-and-add multiplier with a start/done handshake.
// Fixed latency of WIDTH clocks from the accepting edge to done.
module sequential_multiplier
  import sequential_multiplier_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  // Handshake: start is sampled only in IDLE or DONE; done is a level that
  // stays high with a valid product until the next accepted start or rst.
  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        count_q, count_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 done_q, done_d;

  logic [2*WIDTH-1:0]   add_term;
  logic [2*WIDTH-1:0]   acc_sum;

  assign add_term = mplier_q[0] ? mcand_q : '0;
  assign acc_sum  = acc_q + add_term;

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    count_d   = count_q;
    product_d = product_q;
    done_d    = done_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          mcand_d  = {{WIDTH{1'b0}}, a};
          mplier_d = b;
          acc_d    = '0;
          count_d  = '0;
          done_d   = 1'b0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CW'(1);
        // The last iteration's add is folded straight into the result.
        if (count_q == LAST_ITER) begin
          product_d = acc_sum;
          done_d    = 1'b1;
          state_d   = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  assign product = product_q;
  assign done    = done_q;
  assign busy    = (state_q == ST_RUN);

endmodule

// File: tb/tb_sequential_multiplier.sv
// Self-checking bench for sequential_multiplier: directed cases plus a
// randomised sweep checked against plain a*b and a fixed-latency model.
module tb_sequential_multiplier;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [2*W-1:0] product;
  logic           busy;
  logic           done;

  int n_checks = 0;
  int n_pass   = 0;
  logic [2*W-1:0] exp_q[$];

  sequential_multiplier #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .product (product),
    .busy    (busy),
    .done    (done)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Waits for done, counting edges since the accepting edge; while the
  // operation runs busy must be high and product must keep its old value.
  task automatic wait_done(input int lat0, input string tag, input logic [2*W-1:0] prev,
                           output int lat);
    int busy_bad = 0;
    int hold_bad = 0;
    lat = lat0;
    while (done !== 1'b1 && lat < 4 * W) begin
      if (busy !== 1'b1) busy_bad++;
      if (product !== prev) hold_bad++;
      step();
      lat++;
    end
    check({tag, "_latency"}, lat, W);
    check({tag, "_busy_run"}, busy_bad, 0);
    check({tag, "_hold_run"}, hold_bad, 0);
    check({tag, "_busy_done"}, {31'd0, busy}, 0);
  endtask

  task automatic check_product(input string tag);
    logic [2*W-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_product"}, {16'd0, product}, {16'd0, e});
    end
  endtask

  // Driver: present operands with a one-cycle start pulse and check the result.
  task automatic run_op(input logic [W-1:0] a_v, input logic [W-1:0] b_v, input string tag);
    logic [2*W-1:0] prev;
    int lat;
    prev  = product;
    a     = a_v;
    b     = b_v;
    start = 1'b1;
    exp_q.push_back((2*W)'(a_v) * (2*W)'(b_v));
    step();
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    wait_done(0, tag, prev, lat);
    check_product(tag);
  endtask

  initial begin
    int lat;
    int bad;
    int gap;
    logic [2*W-1:0] prev;
    logic [2*W-1:0] held;

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    step();
    check("reset_product", {16'd0, product}, 0);
    check("reset_done", {31'd0, done}, 0);
    check("reset_busy", {31'd0, busy}, 0);
    step();
    rst = 1'b0;

    // Basic multiply, then result holds while idle
    run_op(8'd13, 8'd11, "basic");
    held = product;
    bad  = 0;
    repeat (20) begin
      step();
      if (done !== 1'b1 || product !== held || busy !== 1'b0) bad++;
    end
    check("basic_hold20", bad, 0);

    run_op(8'd255, 8'd255, "max");
    run_op(8'd0, 8'd200, "zero");
    run_op(8'd1, 8'd128, "one");

    // start during RUN must be ignored
    prev  = product;
    a = 8'd6; b = 8'd7; start = 1'b1;
    exp_q.push_back(16'd42);
    step();
    start = 1'b0;
    step();
    step();
    a = 8'd100; b = 8'd100; start = 1'b1;
    step();
    step();
    start = 1'b0;
    wait_done(4, "ignored", prev, lat);
    check_product("ignored");

    // Reset in the fourth RUN cycle aborts without exposing a partial result
    a = 8'd20; b = 8'd12; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    check("midrst_busy_before", {31'd0, busy}, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_busy", {31'd0, busy}, 0);
    check("midrst_done", {31'd0, done}, 0);
    check("midrst_product", {16'd0, product}, 0);
    step();
    check("midrst_stays_idle", {31'd0, busy}, 0);
    run_op(8'd3, 8'd5, "after_rst");

    // Back-to-back with start held high
    prev = product;
    a = 8'd9; b = 8'd9; start = 1'b1;
    exp_q.push_back(16'd81);
    step();
    wait_done(0, "b2b_first", prev, lat);
    check_product("b2b_first");
    a = 8'd2; b = 8'd250;
    exp_q.push_back(16'd500);
    step();
    gap = 1;
    check("b2b_done_cleared", {31'd0, done}, 0);
    wait_done(0, "b2b_second", 16'd81, lat);
    gap += lat;
    check("b2b_spacing", gap, W + 1);
    check_product("b2b_second");
    start = 1'b0;
    step();

    // rst and start together from DONE: reset wins
    check("prio_in_done", {31'd0, done}, 1);
    rst = 1'b1; start = 1'b1; a = 8'd7; b = 8'd9;
    step();
    rst = 1'b0; start = 1'b0;
    check("prio_done", {31'd0, done}, 0);
    check("prio_busy", {31'd0, busy}, 0);
    check("prio_product", {16'd0, product}, 0);
    step();
    check("prio_no_start", {31'd0, busy}, 0);

    // Randomised sweep
    for (int i = 0; i < 1000; i++) begin
      run_op(W'($urandom), W'($urandom), "rand");
      repeat ($urandom_range(0, 2)) step();
    end

    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sequential_multiplier.md
Name: sequential_multiplier

Overview:
Multi-cycle unsigned shift-and-add multiplier. It is the inverse-operation companion to the team's repeated-subtraction sequential divider and uses the same start/done handshake. The multiplication time is fixed and depends only on operand width. The block sits alongside the divider in the Digital II arithmetic set and is driven by the same control FSMs and testbenches.

Parameters:
WIDTH, 8, operand width in bits; product width is 2*WIDTH; must be >= 2

Ports:
clk  input  1  rising-edge clock, single clock domain
rst  input  1  synchronous, active-high reset
start  input  1  request pulse/level; sampled only in IDLE or DONE
a  input  WIDTH  multiplicand, unsigned, captured when start is accepted
b  input  WIDTH  multiplier, unsigned, captured when start is accepted
product  output  2*WIDTH  registered result a*b, valid while done=1
busy  output  1  high while an operation is in progress (RUN)
done  output  1  registered level; high from completion until next accepted start or rst

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst). rst has priority over every other input in the same cycle.
- Reset values: state=IDLE, product=0, done=0, busy=0, all internal registers 0.
- States: IDLE, RUN, DONE, encoded in 2 bits.
- IDLE: start=1 captures operands and moves to RUN. start=0 stays in IDLE.
- Operand capture: mcand (2*WIDTH) = zero-extended a; mplier (WIDTH) = b; acc (2*WIDTH) = 0; count = 0.
- RUN, one iteration per clock:
  - if mplier[0], acc <= acc + mcand;
  - mcand <= mcand << 1;
  - mplier <= mplier >> 1;
  - count <= count + 1.
- RUN completion: after exactly WIDTH iterations, the final acc value (including that cycle's add) is written to product. On the same edge: done <= 1, state -> DONE.
- Latency: start accepted at edge N; done=1 and product valid immediately after edge N+WIDTH (N+8 for WIDTH=8). There is no early termination, so latency is constant for all operands, including 0.
- busy = (state==RUN), registered-equivalent. busy and done are never both 1.
- start while in RUN is ignored; the operation in progress is not disturbed and operands are not recaptured.
- DONE: product and done hold indefinitely. start=1 recaptures new operands, clears done on that edge and enters RUN.
- Back-to-back use: start held high continuously yields one result every WIDTH+1 cycles.
- product update rule: product changes only on the completion edge or on reset. During RUN it keeps the previous result.
- Arithmetic: unsigned only. 2*WIDTH bits hold the maximum product (2^WIDTH-1)^2 with no overflow, so no carry out of acc is needed. count is clog2(WIDTH+1) bits.
- Reset mid-operation: rst in RUN aborts the operation. The next cycle is IDLE with product=0, done=0, busy=0. No partial result is exposed.
- Simultaneous rst and start: reset wins and the start is dropped.

Decomposition:
- Shared include (arith_defs.vh): state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2, and default WIDTH. The divider's FSM will move to the same include.
- No sub-module. The datapath (one adder plus two shifters) is small enough to stay inline with the FSM.

Test Plan:
- Basic multiply: rst for 2 cycles, then a=13, b=11, start pulse 1 cycle -> busy=1 for 8 cycles; done=1 exactly 8 edges after the start edge; product=143; done/product hold for 20 idle cycles.
- Extremes: a=255, b=255 -> product=65025 after 8 cycles. a=0, b=200 -> product=0 with the same 8-cycle latency. a=1, b=128 -> 128.
- Ignored start: a=6, b=7 accepted; 3 cycles later drive a=100, b=100, start=1 for 2 cycles -> result still 42 at the original completion edge; inputs not recaptured.
- Reset mid-op: start a=20, b=12, assert rst on RUN cycle 4 -> next cycle state IDLE, product=0, done=0, busy=0. A following start with a=3, b=5 -> 15.
- Back-to-back and product hold: start held high with a=9, b=9, then a=2, b=250 switched at the first done -> products 81 then 500, 9 cycles apart. product reads 81 throughout the second RUN.
- Priority: rst=1 and start=1 in the same cycle from DONE -> IDLE, no operation started, done=0.
- Randomised sweep (secondary): 1000 random operand pairs checked against a*b, each with latency exactly 8.
